// File: rtl/sched_pkg.sv
// Shared types and helpers for the sched_rr crossbar scheduler.
package sched_pkg;

   typedef enum logic [1:0] {
      POL_FIXED  = 2'd0,
      POL_ING_RR = 2'd1,
      POL_DRR    = 2'd2
   } policy_e;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ASSIGN_CONT = 2'd1,
      ASSIGN_NEW  = 2'd2,
      DONE        = 2'd3
   } state_e;

   // Explicit wrap so non-power-of-two port counts stay in range.
   function automatic int wrap_inc(input int v, input int n);
      if (v + 1 >= n) begin
         return 0;
      end else begin
         return v + 1;
      end
   endfunction

   // Encoding 3 behaves like doubly round-robin.
   function automatic policy_e decode_policy(input logic [1:0] p);
      case (p)
         2'd0:    return POL_FIXED;
         2'd1:    return POL_ING_RR;
         default: return POL_DRR;
      endcase
   endfunction

endpackage

// File: rtl/sched_pick_voq.sv
// Combinational search for the first non-empty, untaken VOQ starting at a wrap-around index.
module sched_pick_voq import sched_pkg::*; #(
   parameter  int N_PORTS = 4,
   localparam int PORT_W  = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] empty,
   input  logic [N_PORTS-1:0] taken,
   input  logic [PORT_W-1:0]  start,
   output logic               found,
   output logic [PORT_W-1:0]  idx
);

   // Scan N_PORTS candidates beginning at start, first eligible one wins.
   always_comb begin
      logic [PORT_W-1:0] j;
      found = 1'b0;
      idx   = '0;
      j     = start;
      for (int k = 0; k < N_PORTS; k++) begin
         if (!found && !empty[j] && !taken[j]) begin
            found = 1'b1;
            idx   = j;
         end else begin
            found = found;
         end
         j = PORT_W'(wrap_inc(int'(j), N_PORTS));
      end
   end

endmodule

// File: rtl/sched_rr_chk.sv
// Simulation-only checks on scheduler inputs: busy ingresses must hold distinct egresses.
module sched_rr_chk #(
   parameter  int N_PORTS = 4,
   localparam int PORT_W  = $clog2(N_PORTS)
) (
   input logic                             clk,
   input logic                             rst_n,
   input logic                             sched_en,
   input logic                             sched_busy,
   input logic [N_PORTS-1:0]               is_busy,
   input logic [N_PORTS-1:0][PORT_W-1:0]   busy_voq_num
);

   logic conflict;

   // Pairwise compare of held egresses among busy ingresses.
   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         for (int j = i + 1; j < N_PORTS; j++) begin
            if (is_busy[i] && is_busy[j] && (busy_voq_num[i] == busy_voq_num[j])) begin
               conflict = 1'b1;
            end else begin
               conflict = conflict;
            end
         end
      end
   end

   a_busy_egress_unique: assert property (@(posedge clk) disable iff (!rst_n)
      (sched_en && !sched_busy) |-> !conflict);

endmodule

// File: rtl/sched_rr.sv
// N-port crossbar scheduler: keeps busy ingresses on their egress, then round-robin matches free ones.
// Optional SCHED_EARLY_DONE_EN ends the matching walk once no further grant is possible.
module sched_rr import sched_pkg::*; #(
   parameter  int N_PORTS = 4,
   localparam int PORT_W  = $clog2(N_PORTS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sched_en,
   input  logic [1:0]                    policy,
   input  logic [N_PORTS-1:0]            is_busy,
   input  logic [N_PORTS*PORT_W-1:0]     busy_voq_num,
   input  logic [N_PORTS*N_PORTS-1:0]    voq_empty,
   output logic                          sched_sel_en,
   output logic [N_PORTS*PORT_W-1:0]     sched_sel,
   output logic [N_PORTS-1:0]            sched_sel_vld,
   output logic                          sched_busy
);

   localparam int CNT_W = $clog2(N_PORTS + 1);

   state_e                              state_r;
   policy_e                             pol_r;
   logic [N_PORTS-1:0]                  busy_sh_r;
   logic [N_PORTS-1:0][PORT_W-1:0]      num_sh_r;
   logic [N_PORTS-1:0][N_PORTS-1:0]     empty_sh_r;
   logic [N_PORTS-1:0][PORT_W-1:0]      egr_ptr_r;
   logic [N_PORTS-1:0][PORT_W-1:0]      sel_r;
   logic [PORT_W-1:0]                   ing_ptr_r;
   logic [PORT_W-1:0]                   cur_ing_r;
   logic [CNT_W-1:0]                    cnt_r;
   logic [N_PORTS-1:0]                  taken_r;
   logic [N_PORTS-1:0]                  cont_taken_s;
   logic [PORT_W-1:0]                   start_s;
   logic [PORT_W-1:0]                   pick_idx_s;
   logic                                pick_found_s;
   logic                                exit_s;
`ifdef SCHED_EARLY_DONE_EN
   logic [N_PORTS-1:0]                  rem_r;
`endif

   assign sched_sel = sel_r;
   assign start_s   = (pol_r == POL_FIXED) ? '0 : egr_ptr_r[cur_ing_r];

   // Egresses already held by continuing (busy) ingresses.
   always_comb begin
      cont_taken_s = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (busy_sh_r[i]) begin
            cont_taken_s[num_sh_r[i]] = 1'b1;
         end else begin
            cont_taken_s = cont_taken_s;
         end
      end
   end

`ifdef SCHED_EARLY_DONE_EN
   // Stop when every egress is taken or no unvisited free ingress has anything queued.
   always_comb begin
      logic pend;
      pend = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (rem_r[i] && !busy_sh_r[i] && !(&empty_sh_r[i])) begin
            pend = 1'b1;
         end else begin
            pend = pend;
         end
      end
      exit_s = (&taken_r) || !pend;
   end
`else
   assign exit_s = 1'b0;
`endif

   sched_pick_voq #(.N_PORTS(N_PORTS)) u_pick (
      .empty (empty_sh_r[cur_ing_r]),
      .taken (taken_r),
      .start (start_s),
      .found (pick_found_s),
      .idx   (pick_idx_s)
   );

   sched_rr_chk #(.N_PORTS(N_PORTS)) u_chk (
      .clk          (clk),
      .rst_n        (rst_n),
      .sched_en     (sched_en),
      .sched_busy   (sched_busy),
      .is_busy      (is_busy),
      .busy_voq_num (busy_voq_num)
   );

   // Scheduling FSM, shadow registers, RR pointers and registered grant outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         pol_r         <= POL_FIXED;
         busy_sh_r     <= '0;
         num_sh_r      <= '0;
         empty_sh_r    <= '0;
         egr_ptr_r     <= '0;
         sel_r         <= '0;
         ing_ptr_r     <= '0;
         cur_ing_r     <= '0;
         cnt_r         <= '0;
         taken_r       <= '0;
         sched_sel_en  <= 1'b0;
         sched_sel_vld <= '0;
         sched_busy    <= 1'b0;
`ifdef SCHED_EARLY_DONE_EN
         rem_r         <= '0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               sched_sel_en <= 1'b0;
               if (sched_en) begin
                  pol_r         <= decode_policy(policy);
                  busy_sh_r     <= is_busy;
                  num_sh_r      <= busy_voq_num;
                  empty_sh_r    <= voq_empty;
                  sel_r         <= '0;
                  sched_sel_vld <= '0;
                  taken_r       <= '0;
                  cnt_r         <= '0;
                  cur_ing_r     <= (decode_policy(policy) == POL_FIXED) ? '0 : ing_ptr_r;
                  sched_busy    <= 1'b1;
                  state_r       <= ASSIGN_CONT;
`ifdef SCHED_EARLY_DONE_EN
                  rem_r         <= '1;
`endif
               end
            end
            ASSIGN_CONT: begin
               for (int i = 0; i < N_PORTS; i++) begin
                  if (busy_sh_r[i]) begin
                     sel_r[i]         <= num_sh_r[i];
                     sched_sel_vld[i] <= 1'b1;
                  end
               end
               taken_r <= cont_taken_s;
               state_r <= ASSIGN_NEW;
            end
            ASSIGN_NEW: begin
               if (exit_s) begin
                  sched_sel_en <= 1'b1;
                  state_r      <= DONE;
               end else begin
                  if (!busy_sh_r[cur_ing_r] && pick_found_s) begin
                     sel_r[cur_ing_r]         <= pick_idx_s;
                     sched_sel_vld[cur_ing_r] <= 1'b1;
                     taken_r[pick_idx_s]      <= 1'b1;
                     if (pol_r == POL_DRR) begin
                        egr_ptr_r[cur_ing_r] <= PORT_W'(wrap_inc(int'(pick_idx_s), N_PORTS));
                     end
                  end
                  cur_ing_r <= PORT_W'(wrap_inc(int'(cur_ing_r), N_PORTS));
                  cnt_r     <= cnt_r + 1'b1;
`ifdef SCHED_EARLY_DONE_EN
                  rem_r[cur_ing_r] <= 1'b0;
`endif
                  if (cnt_r == CNT_W'(N_PORTS - 1)) begin
                     sched_sel_en <= 1'b1;
                     state_r      <= DONE;
                  end
               end
            end
            DONE: begin
               sched_sel_en <= 1'b0;
               sched_busy   <= 1'b0;
               if (pol_r == POL_FIXED) begin
                  ing_ptr_r <= '0;
                  egr_ptr_r <= '0;
               end else begin
                  ing_ptr_r <= PORT_W'(wrap_inc(int'(ing_ptr_r), N_PORTS));
               end
               state_r <= IDLE;
            end
            default: begin
               sched_sel_en <= 1'b0;
               sched_busy   <= 1'b0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sched_rr.sv
// Self-checking bench for sched_rr (N_PORTS=4) against a matching model built from the scheduling rules.
module tb_sched_rr;

   localparam int N  = 4;
   localparam int PW = 2;
   localparam int NN = N * N;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            sched_en = 1'b0;
   logic [1:0]      policy = 2'd0;
   logic [N-1:0]    is_busy = '0;
   logic [N*PW-1:0] busy_voq_num = '0;
   logic [NN-1:0]   voq_empty = '0;
   logic            sched_sel_en;
   logic [N*PW-1:0] sched_sel;
   logic [N-1:0]    sched_sel_vld;
   logic            sched_busy;

   int n_checks = 0;
   int n_fail   = 0;

   int              m_ing_ptr;
   int              m_egr_ptr [N];
   logic [N*PW-1:0] exp_sel;
   logic [N-1:0]    exp_vld;
   int              exp_lat;

   sched_rr #(.N_PORTS(N)) dut (
      .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .policy(policy),
      .is_busy(is_busy), .busy_voq_num(busy_voq_num), .voq_empty(voq_empty),
      .sched_sel_en(sched_sel_en), .sched_sel(sched_sel),
      .sched_sel_vld(sched_sel_vld), .sched_busy(sched_busy)
   );

   always #5 clk = ~clk;

   // Compute the expected matching and latency for the inputs currently driven.
   task automatic model_round();
      int pol, start, i, j, s, e;
      bit taken [N];
      bit pend, all_taken;
      pol = (policy == 2'd0) ? 0 : ((policy == 2'd1) ? 1 : 2);
      exp_sel = '0; exp_vld = '0; exp_lat = N + 2;
      for (int k = 0; k < N; k++) taken[k] = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (is_busy[k]) begin
            e = int'(busy_voq_num[k*PW +: PW]);
            exp_sel[k*PW +: PW] = PW'(e);
            exp_vld[k] = 1'b1;
            taken[e] = 1'b1;
         end
      end
      start = (pol == 0) ? 0 : m_ing_ptr;
      for (int k = 0; k < N; k++) begin
         i = (start + k) % N;
`ifdef SCHED_EARLY_DONE_EN
         all_taken = 1'b1; pend = 1'b0;
         for (int q = 0; q < N; q++) if (!taken[q]) all_taken = 1'b0;
         for (int q = k; q < N; q++)
            if (!is_busy[(start + q) % N] && (voq_empty[((start + q) % N)*N +: N] != '1)) pend = 1'b1;
         if (all_taken || !pend) begin
            exp_lat = 3 + k;
            break;
         end
`else
         all_taken = 1'b0; pend = 1'b1;
`endif
         if (!is_busy[i]) begin
            s = (pol == 0) ? 0 : m_egr_ptr[i];
            for (int m = 0; m < N; m++) begin
               j = (s + m) % N;
               if (!voq_empty[i*N + j] && !taken[j]) begin
                  exp_sel[i*PW +: PW] = PW'(j);
                  exp_vld[i] = 1'b1;
                  taken[j] = 1'b1;
                  if (pol == 2) m_egr_ptr[i] = (j + 1) % N;
                  break;
               end
            end
         end
      end
      if (pol >= 1) m_ing_ptr = (m_ing_ptr + 1) % N;
      else begin
         m_ing_ptr = 0;
         for (int k = 0; k < N; k++) m_egr_ptr[k] = 0;
      end
   endtask

   task automatic model_reset();
      m_ing_ptr = 0;
      for (int k = 0; k < N; k++) m_egr_ptr[k] = 0;
   endtask

   task automatic set_legal_random();
      int perm [N];
      int r, t;
      for (int i = 0; i < N; i++) perm[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         r = int'($urandom_range(0, i)); t = perm[i]; perm[i] = perm[r]; perm[r] = t;
      end
      is_busy = N'($urandom);
      for (int i = 0; i < N; i++) busy_voq_num[i*PW +: PW] = PW'(perm[i]);
      case ($urandom_range(0, 2))
         0:       voq_empty = NN'($urandom & $urandom);
         1:       voq_empty = NN'($urandom | $urandom);
         default: voq_empty = NN'($urandom);
      endcase
      policy = 2'($urandom);
   endtask

   // Issue sched_en, scramble inputs afterwards, and wait (bounded) for the result pulse.
   task automatic launch(input bit noise, output int lat, output logic busy1);
      @(negedge clk); sched_en = 1'b1;
      @(negedge clk); sched_en = 1'b0; busy1 = sched_busy; lat = 1;
      policy = 2'($urandom); is_busy = N'($urandom);
      busy_voq_num = (N*PW)'($urandom); voq_empty = NN'($urandom);
      while (sched_sel_en !== 1'b1 && lat < 40) begin
         if (noise) sched_en = 1'($urandom);
         @(negedge clk); lat++;
      end
      sched_en = 1'b0;
      if (lat >= 40) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sched_sel_en, sched_sel, sched_sel_vld, sched_busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got en=%b sel=%h vld=%b busy=%b, expected all 0",
                  sched_sel_en, sched_sel, sched_sel_vld, sched_busy);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_directed(input string name, input logic [1:0] pol, input logic [N-1:0] busy,
                                input logic [N*PW-1:0] num, input logic [NN-1:0] emp,
                                input logic [N*PW-1:0] want_sel, input logic [N-1:0] want_vld);
      int lat; logic b1;
      policy = pol; is_busy = busy; busy_voq_num = num; voq_empty = emp;
      model_round();
      launch(1'b0, lat, b1);
      n_checks++;
      if (lat != exp_lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
      n_checks++;
      if (b1 !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b expected 1", name, b1); end
      n_checks++;
      if (sched_sel !== want_sel || sched_sel_vld !== want_vld) begin
         n_fail++;
         $display("FAIL %s_grants: got sel=%h vld=%b expected sel=%h vld=%b", name, sched_sel, sched_sel_vld, want_sel, want_vld);
      end
      @(negedge clk);
      n_checks++;
      if (sched_sel_en !== 1'b0 || sched_busy !== 1'b0 || sched_sel !== want_sel) begin
         n_fail++;
         $display("FAIL %s_after: got en=%b busy=%b sel=%h expected 0 0 %h", name, sched_sel_en, sched_busy, sched_sel, want_sel);
      end
   endtask

   task automatic test_drr_rotation();
      int lat; logic b1;
      for (int r = 0; r < N; r++) begin
         policy = 2'd2; is_busy = '0; busy_voq_num = '0; voq_empty = {N{4'b1101}};
         model_round();
         launch(1'b0, lat, b1);
         n_checks++;
         if (sched_sel_vld !== (4'b0001 << r) || sched_sel[r*PW +: PW] !== 2'd1 || lat != exp_lat) begin
            n_fail++;
            $display("FAIL drr_round%0d: got vld=%b sel=%h lat=%0d expected vld=%b egress 1 lat=%0d",
                     r, sched_sel_vld, sched_sel, lat, 4'b0001 << r, exp_lat);
         end
      end
   endtask

   task automatic test_reset_mid_round();
      int lat; logic b1; bit seen;
      policy = 2'd1; is_busy = 4'b0010; busy_voq_num = 8'b00_00_11_00; voq_empty = '0;
      @(negedge clk); sched_en = 1'b1;
      @(negedge clk); sched_en = 1'b0;
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({sched_sel_en, sched_sel, sched_sel_vld, sched_busy} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got en=%b sel=%h vld=%b busy=%b expected all 0",
                  sched_sel_en, sched_sel, sched_sel_vld, sched_busy);
      end
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < N + 4; c++) begin
         @(negedge clk);
         if (sched_sel_en !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL mid_reset_no_pulse: got pulse=1 expected 0"); end
      // Only VOQ 0 queued everywhere: the winner reveals where the ingress pointer restarted.
      policy = 2'd1; is_busy = '0; voq_empty = {N{4'b1110}};
      model_round();
      launch(1'b0, lat, b1);
      n_checks++;
      if (sched_sel_vld !== 4'b0001 || sched_sel !== '0 || lat != exp_lat) begin
         n_fail++;
         $display("FAIL post_reset_round: got vld=%b sel=%h lat=%0d expected vld=0001 sel=00 lat=%0d",
                  sched_sel_vld, sched_sel, lat, exp_lat);
      end
   endtask

   task automatic test_done_collision();
      int lat; logic b1;
      set_legal_random();
      model_round();
      launch(1'b0, lat, b1);
      n_checks++;
      if (lat != exp_lat || sched_sel !== exp_sel || sched_sel_vld !== exp_vld) begin
         n_fail++;
         $display("FAIL collision_first: got lat=%0d sel=%h vld=%b expected lat=%0d sel=%h vld=%b",
                  lat, sched_sel, sched_sel_vld, exp_lat, exp_sel, exp_vld);
      end
      set_legal_random();
      model_round();
      sched_en = 1'b1;
      @(negedge clk);
      n_checks++;
      if (sched_busy !== 1'b0 || sched_sel_en !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_idle: got busy=%b en=%b expected 0 0", sched_busy, sched_sel_en);
      end
      @(negedge clk); sched_en = 1'b0; lat = 1;
      n_checks++;
      if (sched_busy !== 1'b1) begin n_fail++; $display("FAIL collision_accept: got busy=%b expected 1", sched_busy); end
      while (sched_sel_en !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat != exp_lat || sched_sel !== exp_sel || sched_sel_vld !== exp_vld) begin
         n_fail++;
         $display("FAIL collision_second: got lat=%0d sel=%h vld=%b expected lat=%0d sel=%h vld=%b",
                  lat, sched_sel, sched_sel_vld, exp_lat, exp_sel, exp_vld);
      end
      @(negedge clk);
   endtask

   task automatic test_random(input int rounds);
      int lat; logic b1;
      for (int r = 0; r < rounds; r++) begin
         set_legal_random();
         if (r % 8 == 0) is_busy = '1;
         model_round();
         launch(1'b1, lat, b1);
         n_checks++;
         if (lat != exp_lat || b1 !== 1'b1 || sched_sel !== exp_sel || sched_sel_vld !== exp_vld) begin
            n_fail++;
            $display("FAIL random_round%0d: got lat=%0d busy=%b sel=%h vld=%b expected lat=%0d busy=1 sel=%h vld=%b",
                     r, lat, b1, sched_sel, sched_sel_vld, exp_lat, exp_sel, exp_vld);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed("fixed_full", 2'd0, 4'b0000, 8'h00, 16'h0000, 8'b11_10_01_00, 4'b1111);
      test_directed("continue", 2'd0, 4'b0101, 8'b00_00_00_10, 16'h0000, 8'b11_00_01_10, 4'b1111);
      test_drr_rotation();
      test_directed("all_empty", 2'd1, 4'b0000, 8'h00, 16'hffff, 8'h00, 4'b0000);
      test_directed("all_busy", 2'd2, 4'b1111, 8'b00_01_11_10, 16'h0000, 8'b00_01_11_10, 4'b1111);
      test_reset_mid_round();
      test_done_collision();
      test_random(40);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sched_rr.md
Name: sched_rr

Overview:
- Parametrised N-port crossbar scheduler for the VOQ switch. Next generation of the 4-port scheduler.
- On each scheduling request it produces a conflict-free ingress->egress matching:
  - busy ingresses keep their current egress;
  - free ingresses are matched to non-empty VOQs under a selectable round-robin policy.
- Sits between the per-ingress VOQ status logic and the crossbar select/egress datapath.

Parameters:
- N_PORTS, 4, number of ingress and egress ports (2..16).
- PORT_W, $clog2(N_PORTS), width of one port index. Derived; not overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sched_en  in  1  one-cycle request to start a scheduling round; accepted only in IDLE
- policy  in  2  0=fixed priority, 1=ingress RR, 2=doubly RR (ingress+egress), 3=treated as 2
- is_busy  in  N_PORTS  bit i: ingress i is mid-packet
- busy_voq_num  in  N_PORTS*PORT_W  field i: egress held by busy ingress i
- voq_empty  in  N_PORTS*N_PORTS  bit i*N_PORTS+j: VOQ j of ingress i is empty
- sched_sel_en  out  1  one-cycle pulse: sched_sel/sched_sel_vld valid and stable until next sched_en
- sched_sel  out  N_PORTS*PORT_W  field i: egress granted to ingress i
- sched_sel_vld  out  N_PORTS  bit i: ingress i holds a grant this round
- sched_busy  out  1  high from sched_en acceptance until the cycle after sched_sel_en

Behaviour:
- Reset (async, rst_n=0) clears:
  - state to IDLE;
  - sched_sel_en, sched_sel, sched_sel_vld, sched_busy to 0;
  - ingress RR pointer and all egress RR pointers to 0.
- Reset mid-round aborts the round with no pulse.
- FSM states are IDLE, ASSIGN_CONT, ASSIGN_NEW, DONE.
- IDLE:
  - On sched_en, capture is_busy, busy_voq_num, voq_empty and policy into shadow registers. Inputs may change afterwards.
  - Clear the grant vectors, load cur_ing = ing_ptr, go to ASSIGN_CONT.
- ASSIGN_CONT (1 cycle):
  - For every busy ingress i: sched_sel[i] = busy_voq_num[i], sched_sel_vld[i] = 1, mark that egress taken.
  - Go to ASSIGN_NEW.
- ASSIGN_NEW (one ingress per cycle, visited in order cur_ing, cur_ing+1, ... mod N_PORTS):
  - Skip the ingress if it is busy.
  - Otherwise pick the first VOQ j that is non-empty and whose egress is not taken, searching from egr_ptr[cur_ing] with wrap-around.
  - If found: grant it, mark egress j taken.
    - If policy≥2, set egr_ptr[cur_ing] = j+1 mod N_PORTS.
  - If none is found, no grant; egr_ptr is unchanged.
  - After N_PORTS visits go to DONE.
- DONE (1 cycle):
  - Pulse sched_sel_en.
  - If policy≥1, ing_ptr += 1 mod N_PORTS.
  - Return to IDLE.
- Policy 0:
  - ing_ptr and egr_ptr are held at 0.
  - Lowest index wins.
- Latency:
  - Without the optional feature, sched_en to sched_sel_en is fixed at N_PORTS+2 cycles.
  - sched_en arriving while not in IDLE is ignored.
- Boundary cases:
  - All VOQs empty and nothing busy: DONE with sched_sel_vld=0.
  - All ingresses busy: still walks ASSIGN_NEW with no new grants.
  - sched_en arriving in the DONE cycle is ignored; it is accepted the next cycle in IDLE.
- Illegal input: two busy ingresses naming the same egress.
  - Guarded by a simulation assertion.
  - Behaviour undefined; no hardware check.
- All index arithmetic is modulo N_PORTS, explicitly wrapped so non-power-of-2 N works.

Optional Feature:
- SCHED_EARLY_DONE_EN. When defined, ASSIGN_NEW exits to DONE as soon as any of these holds:
  - all egresses are taken;
  - all ingresses are visited;
  - no remaining unvisited free ingress has a non-empty VOQ.
- Latency then varies from 3 to N_PORTS+2 cycles.
- When undefined, latency is always deterministic at N_PORTS+2.
- The pointer update rules are identical in both cases.

Decomposition:
- Package sched_pkg holds:
  - policy enum (POL_FIXED, POL_ING_RR, POL_DRR);
  - state enum;
  - a wrap-increment function.
- Sub-module sched_pick_voq (purely combinational):
  - inputs: empty vector, taken mask, start index;
  - outputs: found flag, index;
  - one instance, muxed by cur_ing.

Test Plan:
- N=4, policy=0, nothing busy, voq_empty=all 0 -> after 6 cycles sched_sel = ingress0->0, 1->1, 2->2, 3->3, vld=4'b1111.
- N=4, is_busy=4'b0101, busy_voq_num ing0=2, ing2=0, all VOQs full -> ing0->2, ing2->0, ing1->1, ing3->3.
- N=4, policy=2, only VOQ 1 non-empty on all ingresses, 4 rounds -> winners ing0, ing1, ing2, ing3 in turn, one grant per round.
- N=4, all VOQs empty -> sched_sel_en at cycle 6 with vld=0; pointers unchanged except ing_ptr under policy≥1.
- Assert rst_n low in ASSIGN_NEW -> outputs 0 immediately, no pulse; next sched_en -> normal round from ing_ptr=0.
- N=3 plus SCHED_EARLY_DONE_EN, all busy -> sched_sel_en 3 cycles after sched_en; without the macro -> 5 cycles.
